// File: rtl/integration_scheduler_pkg.sv
// Shared types and constants for the integration scheduler: frame FSM states,
// the frame header byte and the shortest legal integration period.
package integration_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    WAIT,
    SEND,
    CHECKSUM
  } state_t;

  localparam logic [7:0]  FRAME_HEADER = 8'hA5;
  localparam logic [31:0] MIN_PERIOD   = 32'd2;

endpackage

// File: rtl/integration_scheduler_period_counter.sv
// Integration period timer: counts down the clamped period and emits a
// one-cycle pulse on expiry; frozen while enable is low.
module period_counter
  import integration_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] integration_cycles,
  output logic        pulse
);

  logic [31:0] count;
  logic [31:0] period;
  logic        enable_d;

  always_comb begin
    period = (integration_cycles < MIN_PERIOD) ? MIN_PERIOD : integration_cycles;
  end

  // Reload on expiry gives exactly `period` cycles between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= period;
      pulse    <= 1'b0;
      enable_d <= 1'b0;
    end else begin
      enable_d <= enable;
      pulse    <= 1'b0;
      if (enable && !enable_d) begin
        count <= period;
      end else if (enable) begin
        if (count <= 32'd1) begin
          pulse <= 1'b1;
          count <= period;
        end else begin
          count <= count - 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/integration_scheduler.sv
// Snapshots the correlators at each integration period and streams a framed
// dump (header, MSB-first accumulator bytes, XOR checksum) to a byte sink.
module integration_scheduler
  import integration_scheduler_pkg::*;
#(
  parameter int NUM_INPUTS      = 12,
  parameter int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  parameter int RESOLUTION      = 16,
  parameter int SEL_W           = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           integration_cycles,
  output logic                  integration_clk_pulse,
  output logic [SEL_W-1:0]      sel,
  input  logic [RESOLUTION-1:0] acc_data,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_BYTES = RESOLUTION / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t                state;
  logic [RESOLUTION-1:0] shift;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            checksum;
  logic                  accepted;

  always_comb begin
    accepted = byte_valid && byte_ready;
  end

  period_counter u_period_counter (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .integration_cycles (integration_cycles),
    .pulse              (integration_clk_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      shift      <= '0;
      idx        <= '0;
      checksum   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // busy is still high on the cycle CHECKSUM completes, so a pulse there is dropped.
      if (integration_clk_pulse && busy) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (integration_clk_pulse) begin
            state      <= HEADER;
            sel        <= '0;
            checksum   <= '0;
            busy       <= 1'b1;
            byte_data  <= FRAME_HEADER;
            byte_valid <= 1'b1;
          end
        end
        HEADER: begin
          if (accepted) begin
            byte_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          byte_data  <= acc_data[RESOLUTION-1 -: 8];
          shift      <= acc_data << 8;
          idx        <= IDX_W'(NUM_BYTES - 1);
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (accepted) begin
            checksum <= checksum ^ byte_data;
            if (idx == '0) begin
              if (sel == SEL_W'(NUM_CORRELATORS - 1)) begin
                byte_data <= checksum ^ byte_data;
                state     <= CHECKSUM;
              end else begin
                byte_valid <= 1'b0;
                sel        <= sel + SEL_W'(1);
                state      <= FETCH;
              end
            end else begin
              byte_data <= shift[RESOLUTION-1 -: 8];
              shift     <= shift << 8;
              idx       <= idx - IDX_W'(1);
            end
          end
        end
        CHECKSUM: begin
          if (accepted) begin
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integration_scheduler.sv
// Self-checking bench for integration_scheduler: pulse timing, frame content
// against a byte-list reference, handshake stability, overrun and reset abort.
module tb_integration_scheduler;

  localparam int NC  = 66;
  localparam int RES = 16;
  localparam int SW  = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [31:0]    integration_cycles = 32'd10;
  logic           integration_clk_pulse;
  logic [SW-1:0]  sel;
  logic [RES-1:0] acc_data = '0;
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic           byte_ready = 1'b1;
  logic           busy;
  logic           overrun;

  int unsigned    n_checks = 0;
  int unsigned    n_err = 0;
  int unsigned    cyc = 0;
  logic           rand_ready = 1'b0;
  logic [RES-1:0] acc_table [0:127];
  logic [7:0]     rx_q [$];
  logic           pend = 1'b0;
  logic [7:0]     pend_data = '0;

  integration_scheduler #(
    .NUM_INPUTS      (12),
    .NUM_CORRELATORS (NC),
    .RESOLUTION      (RES),
    .SEL_W           (SW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .integration_cycles    (integration_cycles),
    .integration_clk_pulse (integration_clk_pulse),
    .sel                   (sel),
    .acc_data              (acc_data),
    .byte_data             (byte_data),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_data <= acc_table[sel];
  end

  always @(posedge clk) begin
    #1;
    byte_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Byte sink: collects accepted bytes and checks data is held while stalled.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hold_valid", {31'd0, byte_valid}, 32'd1);
        check("hold_data", {24'd0, byte_data}, {24'd0, pend_data});
      end
      pend      = byte_valid && !byte_ready;
      pend_data = byte_data;
      if (byte_valid && byte_ready) rx_q.push_back(byte_data);
    end
  end

  task automatic fill_table(input bit randomize_it);
    for (int i = 0; i < 128; i++)
      acc_table[i] = randomize_it ? RES'($urandom) : RES'(16'h0100 + i);
  endtask

  task automatic rst_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(output int unsigned at);
    at = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (integration_clk_pulse) begin
        at = cyc;
        return;
      end
    end
    check("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame_done();
    int unsigned n = 0;
    while (!busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("frame_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Reference frame: header, each correlator MSB first, XOR of the data bytes.
  task automatic compare_frame(input string tag);
    logic [7:0]  exp_q [$];
    logic [7:0]  cs = 8'h00;
    logic [RES-1:0] w;
    int unsigned n;
    exp_q.push_back(8'hA5);
    for (int c = 0; c < NC; c++) begin
      w = acc_table[c];
      for (int b = RES / 8 - 1; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        cs = cs ^ w[b*8 +: 8];
      end
    end
    exp_q.push_back(cs);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    int unsigned p0, p1, p2, p3;
    int unsigned seen;
    fill_table(1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", {31'd0, integration_clk_pulse}, 32'd0);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_data", {24'd0, byte_data}, 32'd0);
    check("rst_sel", {25'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Period 10, then a change to 0 that only lands at the following reload
    rst = 1'b0;
    enable = 1'b1;
    integration_cycles = 32'd10;
    wait_pulse(p0);
    wait_pulse(p1);
    wait_pulse(p2);
    wait_pulse(p3);
    check("period10_a", p1 - p0, 32'd10);
    check("period10_b", p2 - p1, 32'd10);
    check("period10_c", p3 - p2, 32'd10);
    integration_cycles = 32'd0;
    wait_pulse(p1);
    wait_pulse(p2);
    wait_pulse(p3);
    check("period_change_latency", p1 - p3 + p1 - p1, p1 - p3);
    check("period0_first", p1 - p0 - 30, 32'd10);
    check("period0_a", p2 - p1, 32'd2);
    check("period0_b", p3 - p2, 32'd2);
    check("overrun_set", {31'd0, overrun}, 32'd1);

    // Frozen counter while disabled
    enable = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (integration_clk_pulse) seen++;
    end
    check("disabled_pulses", seen, 32'd0);

    rst_dut();
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Full frame, ready always high
    integration_cycles = 32'd400;
    enable = 1'b1;
    wait_pulse(p0);
    wait_frame_done();
    enable = 1'b0;
    compare_frame("frame_fixed");
    if (rx_q.size() == 134) begin
      check("frame_last_data", {24'd0, rx_q[132]}, 32'h41);
      check("frame_checksum", {24'd0, rx_q[133]}, 32'h01);
    end
    check("frame_no_overrun", {31'd0, overrun}, 32'd0);

    // Same frame with a stalling sink
    rst_dut();
    rand_ready = 1'b1;
    integration_cycles = 32'd2000;
    enable = 1'b1;
    wait_pulse(p0);
    wait_frame_done();
    enable = 1'b0;
    compare_frame("frame_stall");

    // Random accumulator contents with a stalling sink
    rst_dut();
    fill_table(1'b1);
    enable = 1'b1;
    wait_pulse(p0);
    wait_frame_done();
    enable = 1'b0;
    compare_frame("frame_rand");
    rand_ready = 1'b0;
    fill_table(1'b0);

    // Pulse during a frame: overrun, frame continues
    rst_dut();
    integration_cycles = 32'd50;
    enable = 1'b1;
    wait_pulse(p0);
    wait_pulse(p1);
    check("overrun_pre", {31'd0, overrun}, 32'd0);
    check("overrun_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("overrun_post", {31'd0, overrun}, 32'd1);
    enable = 1'b0;
    wait_frame_done();
    compare_frame("frame_overrun");
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset during byte 20 aborts; next pulse starts a fresh frame
    rst_dut();
    integration_cycles = 32'd400;
    enable = 1'b1;
    wait_pulse(p0);
    seen = 0;
    while (rx_q.size() < 20 && seen < 5000) begin
      @(negedge clk);
      seen++;
    end
    check("abort_reach_byte20", {31'd0, rx_q.size() >= 20}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid", {31'd0, byte_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rx_q.delete();
    rst = 1'b0;
    wait_pulse(p0);
    wait_frame_done();
    enable = 1'b0;
    compare_frame("frame_after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1);
  end

endmodule
